nios2_ocimem_arbiter: RTL

Sequences and arbitrates the Nios II on-chip debug memory (OCI RAM) between two requesters: the JTAG debug module's sysclk-side action strobes and the CPU's Avalon debug slave. It owns the single RAM port, the JTAG auto-incrementing address register and the MonDReg readback register. It sits between the debug module wrapper and the OCI RAM inside the CPU's OCI block.

---
 rtl/nios2_ocimem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/nios2_ocimem_arbiter.sv
// OCI RAM sequencer/arbiter between the JTAG debug strobes and the CPU Avalon debug slave.
// Define OCIMEM_RR_ARB_EN for round-robin conflict arbitration; otherwise JTAG always wins.
module nios2_ocimem_arbiter #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] av_address,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [31:0]       av_writedata,
   input  logic [3:0]        av_byteenable,
   output logic              av_waitrequest,
   output logic [31:0]       av_readdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [3:0]        ram_byteen,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       MonDReg,
   output logic              jtag_busy,
   output logic              jtag_overrun
);

   typedef enum logic [1:0] {StIdle, StCpuRd, StJtagRd} state_e;

   state_e              state_q, state_d;
   logic                pend_valid_q, pend_valid_d;
   logic                pend_write_q, pend_write_d;
   logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
   logic [31:0]         pend_data_q, pend_data_d;
   logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
   logic [31:0]         mondreg_q, mondreg_d;
   logic                overrun_q, overrun_d;
   logic                cpu_block_q, cpu_block_d;
   logic                cpu_req, cpu_wins, grant_cpu, grant_jtag, ovr_set;

   logic unused_jdo;
   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

   // A request held across reset is ignored until the CPU drops and re-raises it.
   assign cpu_req     = (av_read | av_write) & ~cpu_block_q;
   assign cpu_block_d = cpu_block_q & (av_read | av_write);

   assign jtag_busy    = pend_valid_q | (state_q == StJtagRd);
   assign jtag_overrun = overrun_q;
   assign MonDReg      = mondreg_q;

`ifdef OCIMEM_RR_ARB_EN
   logic last_cpu_q, last_cpu_d;

   assign cpu_wins   = ~last_cpu_q;
   assign last_cpu_d = grant_cpu ? 1'b1 : (grant_jtag ? 1'b0 : last_cpu_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_cpu_q <= 1'b0;
      end else begin
         last_cpu_q <= last_cpu_d;
      end
   end
`else
   assign cpu_wins = 1'b0;
`endif

   assign grant_cpu  = (state_q == StIdle) & cpu_req & (~pend_valid_q | cpu_wins);
   assign grant_jtag = (state_q == StIdle) & pend_valid_q & ~grant_cpu;

   // JTAG strobe decode and the one-deep pending queue.
   always_comb begin
      jtag_addr_d  = jtag_addr_q;
      pend_valid_d = pend_valid_q;
      pend_write_d = pend_write_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      ovr_set      = 1'b0;

      if (grant_jtag) begin
         pend_valid_d = 1'b0;
      end

      if (take_action_ocimem_a) begin
         jtag_addr_d = jdo[17 +: ADDR_W];
         ovr_set     = take_action_ocimem_b | take_no_action_ocimem_a;
      end else if (take_action_ocimem_b || take_no_action_ocimem_a) begin
         ovr_set = take_action_ocimem_b & take_no_action_ocimem_a;
         if (jtag_busy) begin
            ovr_set = 1'b1;
         end else begin
            pend_valid_d = 1'b1;
            pend_write_d = take_action_ocimem_b;
            pend_addr_d  = jtag_addr_q;
            pend_data_d  = jdo[34:3];
            jtag_addr_d  = jtag_addr_q + ADDR_W'(1);
         end
      end

      overrun_d = ovr_set ? 1'b1 : (take_action_ocimem_a ? 1'b0 : overrun_q);
   end

   // Sequencer: RAM port drive and read-data return.
   always_comb begin
      state_d        = state_q;
      mondreg_d      = mondreg_q;
      av_waitrequest = 1'b1;
      av_readdata    = '0;
      ram_addr       = '0;
      ram_wren       = 1'b0;
      ram_byteen     = 4'h0;
      ram_wdata      = '0;

      unique case (state_q)
         StIdle: begin
            if (grant_cpu) begin
               ram_addr   = av_address;
               ram_byteen = av_byteenable;
               if (av_write) begin
                  ram_wren       = 1'b1;
                  ram_wdata      = av_writedata;
                  av_waitrequest = 1'b0;
               end else begin
                  state_d = StCpuRd;
               end
            end else if (grant_jtag) begin
               ram_addr   = pend_addr_q;
               ram_byteen = 4'hF;
               if (pend_write_q) begin
                  ram_wren  = 1'b1;
                  ram_wdata = pend_data_q;
               end else begin
                  state_d = StJtagRd;
               end
            end
         end
         StCpuRd: begin
            av_waitrequest = 1'b0;
            av_readdata    = ram_rdata;
            state_d        = StIdle;
         end
         StJtagRd: begin
            mondreg_d = ram_rdata;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         pend_valid_q <= 1'b0;
         pend_write_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         jtag_addr_q  <= '0;
         mondreg_q    <= '0;
         overrun_q    <= 1'b0;
         cpu_block_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_write_q <= pend_write_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         jtag_addr_q  <= jtag_addr_d;
         mondreg_q    <= mondreg_d;
         overrun_q    <= overrun_d;
         cpu_block_q  <= cpu_block_d;
      end
   end

endmodule
